// File: rtl/trng_bit_collector.sv
// Ring-oscillator TRNG controller: warms up the oscillators, paces sampling, drops stale
// pipeline bits and packs kept bits into words. Define TRNG_HEALTH_EN for the RCT alarm.
module trng_bit_collector #(
    parameter int WORD_W        = 32,
    parameter int WARMUP_CYCLES = 64,
    parameter int SAMPLE_DIV    = 4,
    parameter int FLUSH_SAMPLES = 2
`ifdef TRNG_HEALTH_EN
    ,
    parameter int RCT_LIMIT     = 16
`endif
) (
    input  logic              clk,
    input  logic              rst_ni,
    input  logic              en_i,
    output logic              ro_en_o,
    output logic              dff_en_o,
    input  logic              random_bit_i,
    output logic [WORD_W-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              busy_o,
    output logic              alarm_o
);
    // Output handshake: a word transfers on a clk edge where valid_o & ready_i; once raised,
    // valid_o/data_o hold until that edge, and ready_i is ignored while valid_o is low.

    localparam int WU_W  = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int FL_W  = (FLUSH_SAMPLES > 1) ? $clog2(FLUSH_SAMPLES) : 1;
    localparam logic [WU_W-1:0]  WU_LAST  = WU_W'(WARMUP_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_W - 1);
    localparam logic [FL_W-1:0]  FL_LAST  = FL_W'((FLUSH_SAMPLES > 0) ? FLUSH_SAMPLES - 1 : 0);
    localparam logic             FLUSH_ON = (FLUSH_SAMPLES > 0);

    typedef enum logic [1:0] {IDLE, WARMUP, COLLECT, VALID} state_e;

    state_e             state_q, state_d;
    logic [WU_W-1:0]    wu_cnt_q;
    logic [DIV_W-1:0]   div_q;
    logic [FL_W-1:0]    flush_cnt_q;
    logic               flushing_q;
    logic [BIT_W-1:0]   bit_cnt_q;
    logic [WORD_W-1:0]  shreg_q;
    logic [WORD_W-1:0]  data_q;
    logic               pulse_q;
    logic               valid_q;
    logic               alarm_q;
    logic               capture;
    logic               keep;
    logic               collecting;
    logic               rct_trip;

    // The core's output for a dff_en pulse is registered, so it is taken one cycle later.
    assign capture    = (state_q == COLLECT) && pulse_q;
    assign keep       = capture && !flushing_q;
    assign collecting = (state_q == COLLECT) && (state_d == COLLECT);

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (en_i && !alarm_q) state_d = WARMUP;
            WARMUP:  if (!en_i) state_d = IDLE;
                     else if (wu_cnt_q == WU_LAST) state_d = COLLECT;
            COLLECT: if (!en_i || rct_trip) state_d = IDLE;
                     else if (keep && (bit_cnt_q == BIT_LAST)) state_d = VALID;
            VALID:   if (valid_q && ready_i) state_d = en_i ? COLLECT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign ro_en_o  = (state_q != IDLE);
    assign dff_en_o = (state_q == COLLECT) && (div_q == DIV_LAST);
    assign busy_o   = (state_q == WARMUP) || (state_q == COLLECT);
    assign valid_o  = valid_q;
    assign data_o   = data_q;
    assign alarm_o  = alarm_q;

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            wu_cnt_q    <= '0;
            div_q       <= '0;
            flush_cnt_q <= '0;
            flushing_q  <= 1'b0;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            data_q      <= '0;
            pulse_q     <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            pulse_q  <= dff_en_o;
            wu_cnt_q <= ((state_q == WARMUP) && (state_d == WARMUP)) ? wu_cnt_q + 1'b1 : '0;
            if (collecting) begin
                div_q <= (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
                if (capture && flushing_q) begin
                    if (flush_cnt_q == FL_LAST) flushing_q  <= 1'b0;
                    else                        flush_cnt_q <= flush_cnt_q + 1'b1;
                end
                if (keep) begin
                    shreg_q   <= {shreg_q[WORD_W-2:0], random_bit_i};
                    bit_cnt_q <= bit_cnt_q + 1'b1;
                end
            end else begin
                // Any exit from COLLECT drops the partial word and re-arms the flush.
                div_q       <= '0;
                flush_cnt_q <= '0;
                flushing_q  <= FLUSH_ON;
                bit_cnt_q   <= '0;
                shreg_q     <= '0;
            end
            if ((state_q == COLLECT) && (state_d == VALID)) begin
                data_q  <= {shreg_q[WORD_W-2:0], random_bit_i};
                valid_q <= 1'b1;
            end else if (valid_q && ready_i) begin
                valid_q <= 1'b0;
            end
        end
    end

`ifdef TRNG_HEALTH_EN
    localparam int RUN_W = (RCT_LIMIT > 1) ? $clog2(RCT_LIMIT) : 1;

    logic [RUN_W-1:0] run_cnt_q;
    logic             last_bit_q;

    // run_cnt_q counts identical kept bits so far; 0 means no reference bit yet.
    assign rct_trip = keep && (run_cnt_q == RUN_W'(RCT_LIMIT - 1)) && (random_bit_i == last_bit_q);

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            run_cnt_q  <= '0;
            last_bit_q <= 1'b0;
            alarm_q    <= 1'b0;
        end else begin
            if (rct_trip)                            alarm_q <= 1'b1;
            else if ((state_q == IDLE) && !en_i)     alarm_q <= 1'b0;
            if ((state_q == IDLE) || (state_q == WARMUP) || rct_trip) begin
                run_cnt_q <= '0;
            end else if (keep) begin
                last_bit_q <= random_bit_i;
                run_cnt_q  <= ((run_cnt_q != '0) && (random_bit_i == last_bit_q)) ?
                              run_cnt_q + 1'b1 : RUN_W'(1);
            end
        end
    end
`else
    assign rct_trip = 1'b0;
    assign alarm_q  = 1'b0;
`endif

endmodule
